bp_table_scheduler: RTL and testbench

//  Sequences the single-port pattern-history SRAM behind the branch predictor. Arbitrates decode-stage

---
 rtl/bp_table_scheduler.sv | 138 +++++++++++++
 tb/tb_bp_table_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_table_scheduler.sv
// Pattern-history SRAM sequencer: init sweep, lookup/update arbitration, and a
// feedback FIFO drained by 2-cycle read-modify-write of 2-bit saturating counters.
module bp_table_scheduler #(
  parameter int         INDEX_WIDTH = 10,
  parameter int         FB_DEPTH    = 4,
  parameter logic [1:0] INIT_CTR    = 2'b10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [INDEX_WIDTH-1:0] req_index,
  output logic                   rsp_valid,
  output logic                   rsp_prediction,
  input  logic                   fb_valid,
  output logic                   fb_ready,
  input  logic [INDEX_WIDTH-1:0] fb_index,
  input  logic                   fb_outcome,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [INDEX_WIDTH-1:0] mem_addr,
  output logic [1:0]             mem_wdata,
  input  logic [1:0]             mem_rdata,
  output logic                   init_done
);

  localparam int CW = $clog2(FB_DEPTH + 1);
  localparam int PW = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RMW} state_t;

  state_t                 state, state_nx;
  logic [INDEX_WIDTH-1:0] init_addr;
  logic [INDEX_WIDTH-1:0] fifo_idx [FB_DEPTH];
  logic                   fifo_out [FB_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [INDEX_WIDTH-1:0] upd_idx;
  logic                   upd_out;
  logic                   rsp_q;
  logic                   full, empty, push, pop, lookup;
  logic [1:0]             sat_val;

  assign full  = (count == CW'(FB_DEPTH));
  assign empty = (count == '0);

  always_comb begin
    if (upd_out) sat_val = (mem_rdata == 2'b11) ? 2'b11 : mem_rdata + 2'b01;
    else         sat_val = (mem_rdata == 2'b00) ? 2'b00 : mem_rdata - 2'b01;
  end

  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    lookup    = 1'b0;
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_INIT: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = init_addr;
        mem_wdata = INIT_CTR;
        if (init_addr == '1) state_nx = S_IDLE;
      end
      S_IDLE: begin
        req_ready = !full;
        // A full FIFO must drain before lookups may starve updates indefinitely.
        if (full || (!req_valid && !empty)) begin
          pop      = 1'b1;
          mem_en   = 1'b1;
          mem_addr = fifo_idx[rd_ptr];
          state_nx = S_RMW;
        end else if (req_valid) begin
          lookup   = 1'b1;
          mem_en   = 1'b1;
          mem_addr = req_index;
        end
      end
      S_RMW: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = upd_idx;
        mem_wdata = sat_val;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_INIT;
    endcase
    // Reset cycle must never touch the SRAM or handshake with neighbours.
    if (rst) begin
      pop       = 1'b0;
      lookup    = 1'b0;
      req_ready = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  assign init_done      = (state != S_INIT) && !rst;
  assign fb_ready       = init_done && !full;
  assign push           = fb_valid && fb_ready;
  assign rsp_valid      = rsp_q && !rst;
  assign rsp_prediction = rsp_valid && mem_rdata[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      init_addr <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rsp_q     <= 1'b0;
      upd_idx   <= '0;
      upd_out   <= 1'b0;
    end else begin
      state <= state_nx;
      rsp_q <= lookup;
      if (state == S_INIT) init_addr <= init_addr + INDEX_WIDTH'(1);
      if (push) begin
        fifo_idx[wr_ptr] <= fb_index;
        fifo_out[wr_ptr] <= fb_outcome;
        wr_ptr <= (wr_ptr == PW'(FB_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        upd_idx <= fifo_idx[rd_ptr];
        upd_out <= fifo_out[rd_ptr];
        rd_ptr  <= (rd_ptr == PW'(FB_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_bp_table_scheduler.sv
// Bench for bp_table_scheduler: behavioural SRAM, directed scenarios, and a
// randomized run checked against a queue/array model of the predictor table.
module tb_bp_table_scheduler;
  localparam int IW = 4;
  localparam int D  = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready;
  logic [IW-1:0] req_index = '0;
  logic          rsp_valid, rsp_prediction;
  logic          fb_valid = 1'b0, fb_ready;
  logic [IW-1:0] fb_index = '0;
  logic          fb_outcome = 1'b0;
  logic          mem_en, mem_we;
  logic [IW-1:0] mem_addr;
  logic [1:0]    mem_wdata, mem_rdata;
  logic          init_done;

  logic [1:0] sram    [N];
  logic [1:0] ref_tbl [N];
  int n_chk = 0, n_pass = 0;

  typedef struct { logic [IW-1:0] idx; logic out; } upd_t;

  bp_table_scheduler #(.INDEX_WIDTH(IW), .FB_DEPTH(D), .INIT_CTR(2'b10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .rsp_valid(rsp_valid), .rsp_prediction(rsp_prediction),
    .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_index(fb_index), .fb_outcome(fb_outcome),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Single-port SRAM, read data one cycle after issue.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  function automatic logic [1:0] sat(input logic [1:0] v, input logic o);
    int n;
    n = int'(v) + (o ? 1 : -1);
    if (n > 3) n = 3;
    if (n < 0) n = 0;
    return n[1:0];
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc(); cyc();
    @(negedge clk);
    n_chk++;
    if ({req_ready, rsp_valid, rsp_prediction, fb_ready, mem_en, mem_we, mem_addr, mem_wdata, init_done} !== '0)
      $display("FAIL reset_outputs: got en=%b we=%b addr=%0d rr=%b fr=%b done=%b, want all 0",
               mem_en, mem_we, mem_addr, req_ready, fb_ready, init_done);
    else n_pass++;
    cyc(); rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      n_chk++;
      if (!(mem_en === 1'b1 && mem_we === 1'b1 && mem_addr === IW'(i) && mem_wdata === 2'b10 &&
            req_ready === 1'b0 && fb_ready === 1'b0 && init_done === 1'b0))
        $display("FAIL init_write[%0d]: got en=%b we=%b addr=%0d wd=%b rr=%b fr=%b done=%b, want 1 1 %0d 10 0 0 0",
                 i, mem_en, mem_we, mem_addr, mem_wdata, req_ready, fb_ready, init_done, i);
      else n_pass++;
      cyc();
    end
    @(negedge clk);
    n_chk++;
    if (!(init_done === 1'b1 && req_ready === 1'b1 && fb_ready === 1'b1 && mem_en === 1'b0))
      $display("FAIL init_done: got done=%b rr=%b fr=%b en=%b, want 1 1 1 0", init_done, req_ready, fb_ready, mem_en);
    else n_pass++;
    for (int i = 0; i < N; i++) ref_tbl[i] = 2'b10;
  endtask

  task automatic test_lookup();
    cyc(); req_valid = 1'b1; req_index = 4'd5;
    @(negedge clk);
    n_chk++;
    if (!(req_ready === 1'b1 && mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === 4'd5))
      $display("FAIL lookup_issue: got rr=%b en=%b we=%b addr=%0d, want 1 1 0 5", req_ready, mem_en, mem_we, mem_addr);
    else n_pass++;
    cyc(); req_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (!(rsp_valid === 1'b1 && rsp_prediction === 1'b1))
      $display("FAIL lookup_rsp: got v=%b p=%b, want 1 1", rsp_valid, rsp_prediction);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b0) $display("FAIL lookup_single_rsp: got v=%b, want 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_saturate(input logic outcome, input int cnt);
    logic [1:0] expw [4];
    logic [1:0] v;
    int nw = 0;
    v = ref_tbl[5];
    for (int k = 0; k < cnt; k++) begin v = sat(v, outcome); expw[k] = v; end
    for (int c = 0; c < 12; c++) begin
      cyc();
      fb_valid = (c < cnt); fb_index = 4'd5; fb_outcome = outcome;
      @(negedge clk);
      if (c < cnt) begin
        n_chk++;
        if (fb_ready !== 1'b1) $display("FAIL sat_push[%0d]: got fb_ready=%b, want 1", c, fb_ready);
        else begin n_pass++; ref_tbl[5] = sat(ref_tbl[5], outcome); end
      end
      if (mem_en === 1'b1 && mem_we === 1'b1) begin
        n_chk++;
        if (nw >= cnt) $display("FAIL sat_extra_write: got addr=%0d wd=%b, want no write", mem_addr, mem_wdata);
        else if (mem_addr !== 4'd5 || mem_wdata !== expw[nw])
          $display("FAIL sat_write[%0d]: got addr=%0d wd=%b, want 5 %b", nw, mem_addr, mem_wdata, expw[nw]);
        else n_pass++;
        nw++;
      end
    end
    fb_valid = 1'b0;
    n_chk++;
    if (nw != cnt) $display("FAIL sat_write_count: got %0d, want %0d", nw, cnt);
    else n_pass++;
    cyc(); req_valid = 1'b1; req_index = 4'd5;
    @(negedge clk);
    cyc(); req_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (!(rsp_valid === 1'b1 && rsp_prediction === ref_tbl[5][1]))
      $display("FAIL sat_lookup: got v=%b p=%b, want 1 %b", rsp_valid, rsp_prediction, ref_tbl[5][1]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc = 0, rsps = 0, wr = 0;
    logic prev = 1'b0, ep = 1'b0;
    for (int c = 0; c < 22; c++) begin
      cyc();
      req_valid = (c < 10); req_index = IW'($urandom_range(0, N - 1));
      fb_valid = (c < 4); fb_index = IW'($urandom_range(0, N - 1)); fb_outcome = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c < 10) begin
        n_chk++;
        if (req_ready !== !(c == 4 || c == 5))
          $display("FAIL b2b_req_ready[%0d]: got %b, want %b", c, req_ready, !(c == 4 || c == 5));
        else n_pass++;
      end
      if (c < 4) begin
        n_chk++;
        if (fb_ready !== 1'b1) $display("FAIL b2b_fb_ready[%0d]: got %b, want 1", c, fb_ready);
        else n_pass++;
      end
      n_chk++;
      if (rsp_valid !== prev) $display("FAIL b2b_rsp_valid[%0d]: got %b, want %b", c, rsp_valid, prev);
      else n_pass++;
      if (rsp_valid === 1'b1) rsps++;
      if (prev) begin
        n_chk++;
        if (rsp_prediction !== ep) $display("FAIL b2b_rsp_pred[%0d]: got %b, want %b", c, rsp_prediction, ep);
        else n_pass++;
      end
      if (mem_en === 1'b1 && mem_we === 1'b1) wr++;
      prev = req_valid && req_ready;
      if (prev) begin ep = sram[req_index][1]; acc++; end
      if (fb_valid && fb_ready) ref_tbl[fb_index] = sat(ref_tbl[fb_index], fb_outcome);
    end
    n_chk++;
    if (wr != 4 || rsps != acc) $display("FAIL b2b_totals: got writes=%0d rsps=%0d, want 4 %0d", wr, rsps, acc);
    else n_pass++;
  endtask

  task automatic test_push_pop();
    int wr = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      req_valid = (c < 3); req_index = IW'($urandom_range(0, N - 1));
      fb_valid = (c < 5); fb_index = IW'($urandom_range(0, N - 1)); fb_outcome = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c == 3) begin
        n_chk++;
        if (!(fb_ready === 1'b1 && mem_en === 1'b1 && mem_we === 1'b0))
          $display("FAIL pp_pop_push: got fr=%b en=%b we=%b, want 1 1 0", fb_ready, mem_en, mem_we);
        else n_pass++;
      end
      if (c == 4) begin
        n_chk++;
        if (!(fb_ready === 1'b1 && mem_we === 1'b1))
          $display("FAIL pp_count_held: got fr=%b we=%b, want 1 1", fb_ready, mem_we);
        else n_pass++;
      end
      if (c == 5) begin
        fb_valid = 1'b0;
        n_chk++;
        if (fb_ready !== 1'b0) $display("FAIL pp_full: got fb_ready=%b, want 0", fb_ready);
        else n_pass++;
      end
      if (mem_en === 1'b1 && mem_we === 1'b1) wr++;
      if (fb_valid && fb_ready) ref_tbl[fb_index] = sat(ref_tbl[fb_index], fb_outcome);
    end
    fb_valid = 1'b0;
    n_chk++;
    if (wr != 5) $display("FAIL pp_writes: got %0d, want 5", wr);
    else n_pass++;
  endtask

  task automatic test_random();
    upd_t q[$];
    logic prev = 1'b0, ep = 1'b0;
    logic [1:0] ew;
    for (int c = 0; c < 330; c++) begin
      cyc();
      if (c < 300) begin
        req_valid = 1'($urandom_range(0, 1)); req_index = IW'($urandom_range(0, N - 1));
        fb_valid = ($urandom_range(0, 9) < 4); fb_index = IW'($urandom_range(0, N - 1));
        fb_outcome = 1'($urandom_range(0, 1));
      end else begin
        req_valid = 1'b0; fb_valid = 1'b0;
      end
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== prev) $display("FAIL rand_rsp_valid[%0d]: got %b, want %b", c, rsp_valid, prev);
      else n_pass++;
      if (prev) begin
        n_chk++;
        if (rsp_prediction !== ep) $display("FAIL rand_rsp_pred[%0d]: got %b, want %b", c, rsp_prediction, ep);
        else n_pass++;
      end
      if (mem_en === 1'b1 && mem_we === 1'b1) begin
        n_chk++;
        if (q.size() == 0) $display("FAIL rand_write[%0d]: got addr=%0d, want no write", c, mem_addr);
        else begin
          ew = sat(sram[q[0].idx], q[0].out);
          if (mem_addr !== q[0].idx || mem_wdata !== ew)
            $display("FAIL rand_write[%0d]: got addr=%0d wd=%b, want %0d %b", c, mem_addr, mem_wdata, q[0].idx, ew);
          else n_pass++;
          void'(q.pop_front());
        end
      end
      prev = req_valid && req_ready;
      if (prev) ep = sram[req_index][1];
      if (fb_valid && fb_ready) begin
        q.push_back('{fb_index, fb_outcome});
        ref_tbl[fb_index] = sat(ref_tbl[fb_index], fb_outcome);
      end
    end
    n_chk++;
    if (q.size() != 0) $display("FAIL rand_drain: got %0d pending, want 0", q.size());
    else n_pass++;
  endtask

  task automatic test_table();
    for (int i = 0; i < N; i++) begin
      n_chk++;
      if (sram[i] !== ref_tbl[i]) $display("FAIL table[%0d]: got %b, want %b", i, sram[i], ref_tbl[i]);
      else n_pass++;
    end
  endtask

  task automatic test_rst_rmw();
    cyc(); fb_valid = 1'b1; fb_index = 4'd9; fb_outcome = 1'b1;
    @(negedge clk);
    cyc(); fb_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (!(mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === 4'd9))
      $display("FAIL rr_pop: got en=%b we=%b addr=%0d, want 1 0 9", mem_en, mem_we, mem_addr);
    else n_pass++;
    cyc(); rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (!(mem_en === 1'b0 && mem_we === 1'b0 && init_done === 1'b0))
      $display("FAIL rr_no_write: got en=%b we=%b done=%b, want 0 0 0", mem_en, mem_we, init_done);
    else n_pass++;
    cyc(); rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      n_chk++;
      if (!(mem_en === 1'b1 && mem_we === 1'b1 && mem_addr === IW'(i) && mem_wdata === 2'b10 && fb_ready === 1'b0))
        $display("FAIL rr_init[%0d]: got en=%b we=%b addr=%0d wd=%b fr=%b, want 1 1 %0d 10 0",
                 i, mem_en, mem_we, mem_addr, mem_wdata, fb_ready, i);
      else n_pass++;
      cyc();
    end
    for (int i = 0; i < N; i++) ref_tbl[i] = 2'b10;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (!(mem_en === 1'b0 && init_done === 1'b1 && fb_ready === 1'b1))
        $display("FAIL rr_discard[%0d]: got en=%b done=%b fr=%b, want 0 1 1", c, mem_en, init_done, fb_ready);
      else n_pass++;
      cyc();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lookup();
    test_saturate(1'b0, 3);
    test_saturate(1'b1, 4);
    test_back_to_back();
    test_push_pop();
    test_random();
    test_table();
    test_rst_rmw();
    test_table();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
